fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 ir_addr_valid  output  1  instruction-bus address request valid.
REQ-005 ir_addr_ready  input  1  bus accepts address.
REQ-006 ir_addr  output  32  fetch address, word aligned.
REQ-007 ir_data_valid  input  1  bus returns instruction word.
REQ-008 ir_data_ready  output  1  unit accepts returned word.
REQ-009 ir_data  input  32  returned instruction word.
REQ-010 inst_valid  output  1  inst/inst_pc hold an instruction for the decoder.
REQ-011 inst_ready  input  1  decoder consumes inst.
REQ-012 inst  output  32  instruction word driven to decoder inst input.
REQ-013 inst_pc  output  32  address the current inst was fetched from.
REQ-014 redirect  input  1  single-cycle flush/branch-taken pulse.
REQ-015 redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 00).

Function
REQ-016 State machine SHALL have states IDLE, REQ, WAIT, FULL, DISCARD; one request outstanding at most.
REQ-017 Internal register fetch_pc SHALL supply ir_addr directly (ir_addr == fetch_pc).
REQ-018 IDLE: all handshake outputs 0; next state REQ unconditionally.
REQ-019 REQ: ir_addr_valid=1; ir_addr SHALL remain stable until ir_addr_valid&&ir_addr_ready, except on redirect; on handshake -> WAIT.
REQ-020 WAIT: ir_data_ready=1; on ir_data_valid: inst<=ir_data, inst_pc<=fetch_pc, fetch_pc<=fetch_pc+4 -> FULL.
REQ-021 FULL: inst_valid=1 (masked to 0 in any cycle redirect=1); on inst_valid&&inst_ready -> REQ; otherwise inst, inst_pc held unchanged.
REQ-022 DISCARD: ir_data_ready=1; on ir_data_valid word dropped (inst, inst_pc unchanged) -> REQ.
REQ-023 ir_addr_valid=1 only in REQ; ir_data_ready=1 only in WAIT and DISCARD; outputs decoded from state register only (except inst_valid masking by redirect).
REQ-024 fetch_pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-025 redirect (outside reset) SHALL load fetch_pc <= {redirect_pc[31:2],2'b00} in every state, with priority over the +4 increment.
REQ-026 redirect transitions: IDLE->REQ; REQ without address handshake ->REQ (new address presented next cycle); REQ with address handshake same cycle ->DISCARD; WAIT with ir_data_valid same cycle ->REQ, word dropped; WAIT without ir_data_valid ->DISCARD; FULL ->REQ, held instruction dropped regardless of inst_ready; DISCARD ->DISCARD (stale response still owed).
REQ-027 Minimum latency: address handshake in cycle N, data in N+1 -> inst_valid=1 in N+2; next ir_addr_valid the cycle after consumption.
REQ-028 Dropped instructions SHALL never appear with inst_valid=1.

Reset
REQ-029 While rst=1: state<=IDLE, fetch_pc<=RESET_PC, inst<=0, inst_pc<=0; redirect ignored.
REQ-030 Resulting outputs in the cycle after any rst=1 edge: ir_addr_valid=0, ir_data_ready=0, inst_valid=0, ir_addr=RESET_PC.
REQ-031 rst mid-transaction SHALL abandon any outstanding request; bus responses during reset ignored.

Verification
REQ-032 Reset RESET_PC=0; ir_addr_ready=1, data returned 1 cycle later (0x00500093), inst_ready=1 -> inst_valid with inst=0x00500093, inst_pc=0; next ir_addr=4.
REQ-033 Backpressure: inst_ready=0 for 5 cycles while FULL -> inst/inst_pc stable, no new ir_addr_valid; inst_ready=1 -> single transfer, then REQ addr=+4.
REQ-034 redirect to 0x103 while WAIT, data arrives 3 cycles later -> word dropped, never inst_valid; next ir_addr=0x100, delivered inst_pc=0x100.
REQ-035 redirect in FULL with inst_ready=1 same cycle -> inst_valid=0 that cycle, held inst never delivered, next ir_addr=redirect target.
REQ-036 fetch_pc=0xFFFFFFFC fetched -> inst_pc=0xFFFFFFFC, next ir_addr=0x00000000.
REQ-037 rst asserted in WAIT with ir_data_valid same cycle -> inst_valid stays 0, ir_addr returns to RESET_PC, IDLE then REQ.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding request on a valid/ready instruction bus,
// a single-entry holding register for the decoder, and redirect/flush handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ir_addr_valid,
  input  logic        ir_addr_ready,
  output logic [31:0] ir_addr,
  input  logic        ir_data_valid,
  output logic        ir_data_ready,
  input  logic [31:0] ir_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_FULL    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;

  logic addr_hs;
  logic data_hs;
  logic unused_ok;

  assign addr_hs   = ir_addr_valid && ir_addr_ready;
  assign data_hs   = ir_data_ready && ir_data_valid;
  assign unused_ok = ^redirect_pc[1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: state_next = ST_REQ;
      ST_REQ: begin
        if (addr_hs) begin
          state_next = redirect ? ST_DISCARD : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (ir_data_valid) begin
          state_next = redirect ? ST_REQ : ST_FULL;
        end else if (redirect) begin
          state_next = ST_DISCARD;
        end
      end
      ST_FULL: begin
        if (redirect || inst_ready) begin
          state_next = ST_REQ;
        end
      end
      // A response arriving here settles the only outstanding request,
      // so a coincident redirect needs nothing more than the new fetch_pc.
      ST_DISCARD: begin
        if (ir_data_valid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the state register only; redirect masks the decoder handoff
  always_comb begin
    ir_addr_valid = 1'b0;
    ir_data_ready = 1'b0;
    inst_valid    = 1'b0;
    case (state_reg)
      ST_REQ:     ir_addr_valid = 1'b1;
      ST_WAIT:    ir_data_ready = 1'b1;
      ST_DISCARD: ir_data_ready = 1'b1;
      ST_FULL:    inst_valid    = !redirect;
      default: ;
    endcase
  end

  // Datapath: redirect wins over the sequential increment
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg <= RESET_PC;
      inst_reg     <= 32'h0;
      inst_pc_reg  <= 32'h0;
    end else begin
      if (redirect) begin
        fetch_pc_reg <= {redirect_pc[31:2], 2'b00};
      end else if (state_reg == ST_WAIT && data_hs) begin
        fetch_pc_reg <= fetch_pc_reg + 32'd4;
      end
      if (state_reg == ST_WAIT && data_hs && !redirect) begin
        inst_reg    <= ir_data;
        inst_pc_reg <= fetch_pc_reg;
      end
    end
  end

  assign ir_addr = fetch_pc_reg;
  assign inst    = inst_reg;
  assign inst_pc = inst_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit: each record holds the inputs
// for one cycle and the outputs expected in that cycle before the next rising edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid;
  logic        ir_addr_ready;
  logic [31:0] ir_addr;
  logic        ir_data_valid;
  logic        ir_data_ready;
  logic [31:0] ir_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .ir_addr_valid (ir_addr_valid),
    .ir_addr_ready (ir_addr_ready),
    .ir_addr       (ir_addr),
    .ir_data_valid (ir_data_valid),
    .ir_data_ready (ir_data_ready),
    .ir_data       (ir_data),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        ar;
    logic        dv;
    logic [31:0] data;
    logic        ir;
    logic        rd;
    logic [31:0] rpc;
    logic        e_av;
    logic [31:0] e_addr;
    logic        e_dr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [31:0] D0 = 32'h0050_0093;

  task automatic add(input string name, input logic r, input logic ar, input logic dv,
                     input logic [31:0] data, input logic ir, input logic rd,
                     input logic [31:0] rpc, input logic e_av, input logic [31:0] e_addr,
                     input logic e_dr, input logic e_iv, input logic [31:0] e_inst,
                     input logic [31:0] e_pc);
    vec_t v;
    v.name = name; v.rst = r; v.ar = ar; v.dv = dv; v.data = data; v.ir = ir;
    v.rd = rd; v.rpc = rpc; v.e_av = e_av; v.e_addr = e_addr; v.e_dr = e_dr;
    v.e_iv = e_iv; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst           = v.rst;
    ir_addr_ready = v.ar;
    ir_data_valid = v.dv;
    ir_data       = v.data;
    inst_ready    = v.ir;
    redirect      = v.rd;
    redirect_pc   = v.rpc;
    #2;
    n_vec++;
    if (ir_addr_valid !== v.e_av || ir_addr !== v.e_addr || ir_data_ready !== v.e_dr ||
        inst_valid !== v.e_iv || inst !== v.e_inst || inst_pc !== v.e_pc) begin
      n_bad++;
      $display("FAIL %s: got av=%b addr=%h dr=%b iv=%b inst=%h pc=%h, want av=%b addr=%h dr=%b iv=%b inst=%h pc=%h",
               v.name, ir_addr_valid, ir_addr, ir_data_ready, inst_valid, inst, inst_pc,
               v.e_av, v.e_addr, v.e_dr, v.e_iv, v.e_inst, v.e_pc);
    end else begin
      $display("vec %0d %s ok: av=%b addr=%h dr=%b iv=%b inst=%h pc=%h",
               n_vec, v.name, ir_addr_valid, ir_addr, ir_data_ready, inst_valid, inst, inst_pc);
    end
  endtask

  initial begin
    rst = 1'b1; ir_addr_ready = 1'b0; ir_data_valid = 1'b0; ir_data = 32'h0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (2) @(posedge clk);

    //   name         rst ar dv data          ir rd rpc            av addr          dr iv inst          pc
    add("reset",      1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);
    add("idle",       0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);
    add("req0",       0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 0, 32'h0,        32'h0);
    add("wait0",      0, 0, 1, D0,           0, 0, 32'h0,         0, 32'h0,        1, 0, 32'h0,        32'h0);
    add("full0",      0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h4,        0, 1, D0,           32'h0);
    add("req4_stall", 0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, 0, D0,           32'h0);
    add("req4",       0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h4,        0, 0, D0,           32'h0);
    add("wait4_idle", 0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h4,        1, 0, D0,           32'h0);
    add("wait4",      0, 0, 1, 32'h1111_1111, 0, 0, 32'h0,        0, 32'h4,        1, 0, D0,           32'h0);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // Backpressure: decoder stalls five cycles, bus stays willing but must not be asked
    for (int k = 0; k < 5; k++) begin
      vec_t v;
      v.name = $sformatf("stall%0d", k);
      v.rst = 0; v.ar = 1; v.dv = 0; v.data = 32'h0; v.ir = 0; v.rd = 0; v.rpc = 32'h0;
      v.e_av = 0; v.e_addr = 32'h8; v.e_dr = 0; v.e_iv = 1; v.e_inst = 32'h1111_1111; v.e_pc = 32'h4;
      apply(v);
    end

    add("release",    0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8,        0, 1, 32'h1111_1111, 32'h4);
    add("req8",       0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h8,        0, 0, 32'h1111_1111, 32'h4);
    add("wait8",      0, 0, 1, 32'h2222_2222, 0, 0, 32'h0,        0, 32'h8,        1, 0, 32'h1111_1111, 32'h4);
    add("full_redir", 0, 0, 0, 32'h0,        1, 1, 32'h200,       0, 32'hC,        0, 0, 32'h2222_2222, 32'h8);
    add("req200",     0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h200,      0, 0, 32'h2222_2222, 32'h8);
    add("req_redir",  0, 0, 0, 32'h0,        0, 1, 32'hFFFF_FFFE, 1, 32'h200,      0, 0, 32'h2222_2222, 32'h8);
    add("req_top",    0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0, 32'h2222_2222, 32'h8);
    add("wait_top",   0, 0, 1, 32'h3333_3333, 0, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 0, 32'h2222_2222, 32'h8);
    add("full_top",   0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 1, 32'h3333_3333, 32'hFFFF_FFFC);
    add("req_wrap",   0, 0, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // Redirect while waiting; the stale word shows up three cycles later and must vanish
    add("req_w",      0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h0,        0, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("wait_redir", 0, 0, 0, 32'h0,        0, 1, 32'h103,       0, 32'h0,        1, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("discard1",   0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h100,      1, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("discard2",   0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h100,      1, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("discard3",   0, 0, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,        0, 32'h100,      1, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("req100",     0, 1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h100,      0, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("wait100",    0, 0, 1, 32'h4444_4444, 1, 0, 32'h0,        0, 32'h100,      1, 0, 32'h3333_3333, 32'hFFFF_FFFC);
    add("full100",    0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h104,      0, 1, 32'h4444_4444, 32'h100);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    // Reset in WAIT with the data arriving on the same edge, then the REQ/WAIT redirect corners
    add("req104",     0, 1, 0, 32'h0,        0, 0, 32'h0,         1, 32'h104,      0, 0, 32'h4444_4444, 32'h100);
    add("wait_rst",   1, 0, 1, 32'h5555_5555, 1, 0, 32'h0,        0, 32'h104,      1, 0, 32'h4444_4444, 32'h100);
    add("idle_rst",   0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);
    add("req_rst",    0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h0,        0, 0, 32'h0,        32'h0);
    add("req_hs_rd",  0, 1, 0, 32'h0,        1, 1, 32'h40,        1, 32'h0,        0, 0, 32'h0,        32'h0);
    add("discard40",  0, 0, 1, 32'h66,       1, 0, 32'h0,         0, 32'h40,       1, 0, 32'h0,        32'h0);
    add("req40",      0, 1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h40,       0, 0, 32'h0,        32'h0);
    add("wait_dv_rd", 0, 0, 1, 32'h77,       1, 1, 32'h80,        0, 32'h40,       1, 0, 32'h0,        32'h0);
    add("req80",      0, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h80,       0, 0, 32'h0,        32'h0);
    add("rst_rd",     1, 0, 0, 32'h0,        1, 1, 32'h300,       1, 32'h80,       0, 0, 32'h0,        32'h0);
    add("idle_final", 0, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 0, 32'h0,        32'h0);
    foreach (vecs[i]) apply(vecs[i]);
    vecs.delete();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary line");
    $fatal(1);
  end

endmodule
